mem_access_controller: RTL and testbench

Sequences data-memory accesses for the MEM stage of the 5-stage pipeline. It takes load/store requests from the EX/MEM register and drives a variable-latency data-memory request/ack handshake, and it generates byte enables and lane-aligned store data. It also sign- or zero-extends load data and stalls the pipeline registers, including mem_wb_register, until the access completes. Misaligned accesses, illegal width codes and memory timeouts raise a sticky fault.

---
 rtl/mem_access_controller_pkg.sv | 29 ++
 rtl/mem_access_controller_if.sv | 22 ++
 rtl/mem_access_controller_align.sv | 70 +++++++
 rtl/mem_access_controller.sv | 162 ++++++++++++++++
 tb/tb_mem_access_controller.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_controller_pkg.sv
// rtl/mem_access_controller_pkg.sv - shared types and constants for the MEM-stage access controller
// Contents: FSM state encoding, funct3 width codes, fault cause codes, default timeout.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] CAUSE_NONE       = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGNED = 2'd1;
    localparam logic [1:0] CAUSE_ILLEGAL    = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT    = 2'd3;

    localparam int TIMEOUT_DEFAULT = 255;
    localparam int CNT_W_DEFAULT   = 10;

endpackage

// File: rtl/mem_access_controller_if.sv
// rtl/mem_access_controller_if.sv - data-memory request/ack bus
// Signals: dmem_req/we/addr/be/wdata (controller -> memory), dmem_ack/rdata (memory -> controller).
// Modports: master (controller side), slave (memory side).
interface dmem_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access_controller_align.sv
// rtl/mem_access_controller_align.sv - combinational width decode, lane alignment and load extension
// Inputs:  funct3, off (addr[1:0]), is_load, is_store, store_data, rdata.
// Outputs: be, wdata (lane-replicated), load_data (extracted/extended), legal, misaligned.
module load_store_align
    import mem_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        legal,
    output logic        misaligned
);

    logic       sz_byte;
    logic       sz_half;
    logic       sz_word;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        sz_byte = (funct3 == F3_LB) || (funct3 == F3_LBU);
        sz_half = (funct3 == F3_LH) || (funct3 == F3_LHU);
        sz_word = (funct3 == F3_LW);

        legal = 1'b0;
        if (is_load && !is_store) begin
            legal = sz_byte || sz_half || sz_word;
        end else if (is_store && !is_load) begin
            legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        end

        misaligned = (sz_half && off[0]) || (sz_word && (off != 2'b00));

        // Loads always fetch the whole word; the lane is picked out on return.
        be    = 4'b1111;
        wdata = store_data;
        if (is_store) begin
            if (funct3 == F3_SB) begin
                be    = 4'b0001 << off;
                wdata = {4{store_data[7:0]}};
            end else if (funct3 == F3_SH) begin
                be    = 4'b0011 << off;
                wdata = {2{store_data[15:0]}};
            end
        end

        case (off)
            2'd0:    lane_byte = rdata[7:0];
            2'd1:    lane_byte = rdata[15:8];
            2'd2:    lane_byte = rdata[23:16];
            default: lane_byte = rdata[31:24];
        endcase
        lane_half = off[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
            F3_LBU:  load_data = {24'd0, lane_byte};
            F3_LH:   load_data = {{16{lane_half[15]}}, lane_half};
            F3_LHU:  load_data = {16'd0, lane_half};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_controller.sv
// rtl/mem_access_controller.sv - MEM-stage load/store sequencer with variable-latency memory handshake
// Ports: clock (falling-edge active), reset (sync, active-high); mem_read_in, mem_write_in, funct3_in,
//        addr_in, store_data_in from EX/MEM; stall_out, load_data_out, load_valid_out, fault_out,
//        fault_cause_out to the pipeline; dmem (dmem_if.master) to data memory.
module mem_access_controller
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int CNT_W          = CNT_W_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    output logic        stall_out,
    output logic [31:0] load_data_out,
    output logic        load_valid_out,
    output logic        fault_out,
    output logic [1:0]  fault_cause_out,
    dmem_if.master      dmem
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic             is_load_q;
    logic             access;
    logic             stall_c;

    logic [2:0]  sel_f3;
    logic [1:0]  sel_off;
    logic        sel_load;
    logic        sel_store;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_load;
    logic        al_legal;
    logic        al_mis;

    assign access = mem_read_in | mem_write_in;

    // In IDLE the aligner decodes the live request; afterwards it works on the
    // latched width/offset so the returning word is extracted for the right access.
    assign sel_f3    = (state == ST_IDLE) ? funct3_in    : f3_q;
    assign sel_off   = (state == ST_IDLE) ? addr_in[1:0] : off_q;
    assign sel_load  = (state == ST_IDLE) ? mem_read_in  : is_load_q;
    assign sel_store = (state == ST_IDLE) ? mem_write_in : !is_load_q;

    load_store_align u_align (
        .funct3     (sel_f3),
        .off        (sel_off),
        .is_load    (sel_load),
        .is_store   (sel_store),
        .store_data (store_data_in),
        .rdata      (dmem.dmem_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .legal      (al_legal),
        .misaligned (al_mis)
    );

    always_comb begin
        next_state = state;
        stall_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access) begin
                    stall_c    = 1'b1;
                    next_state = (al_legal && !al_mis) ? ST_WAIT : ST_ERROR;
                end
            end
            ST_WAIT: begin
                stall_c = 1'b1;
                // Ack wins over a simultaneous timeout.
                if (dmem.dmem_ack) begin
                    next_state = ST_DONE;
                end else if (cnt == CNT_LIMIT) begin
                    next_state = ST_ERROR;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                stall_c = 1'b1;
            end
        endcase
    end

    assign stall_out = stall_c & ~reset;

    always_ff @(negedge clock) begin
        if (reset) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            f3_q            <= '0;
            off_q           <= '0;
            is_load_q       <= 1'b0;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_be    <= '0;
            dmem.dmem_wdata <= '0;
            load_data_out   <= '0;
            load_valid_out  <= 1'b0;
            fault_out       <= 1'b0;
            fault_cause_out <= CAUSE_NONE;
        end else begin
            state <= next_state;
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        if (al_legal && !al_mis) begin
                            dmem.dmem_req   <= 1'b1;
                            dmem.dmem_we    <= mem_write_in;
                            dmem.dmem_addr  <= {addr_in[31:2], 2'b00};
                            dmem.dmem_be    <= al_be;
                            dmem.dmem_wdata <= al_wdata;
                            cnt             <= '0;
                            f3_q            <= funct3_in;
                            off_q           <= addr_in[1:0];
                            is_load_q       <= mem_read_in;
                        end else begin
                            fault_out       <= 1'b1;
                            // An illegal code makes alignment meaningless, so it takes priority.
                            fault_cause_out <= al_legal ? CAUSE_MISALIGNED : CAUSE_ILLEGAL;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dmem.dmem_ack) begin
                        dmem.dmem_req <= 1'b0;
                        if (is_load_q) begin
                            load_data_out  <= al_load;
                            load_valid_out <= 1'b1;
                        end
                    end else if (cnt == CNT_LIMIT) begin
                        dmem.dmem_req   <= 1'b0;
                        fault_out       <= 1'b1;
                        fault_cause_out <= CAUSE_TIMEOUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    load_valid_out <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_controller.sv
// tb/tb_mem_access_controller.sv - self-checking bench for mem_access_controller
module tb_mem_access_controller;

    localparam int TO = 4;
    localparam int L  = TO + 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_read_in = 1'b0;
    logic        mem_write_in = 1'b0;
    logic [2:0]  funct3_in = 3'd0;
    logic [31:0] addr_in = 32'd0;
    logic [31:0] store_data_in = 32'd0;
    logic        stall_out;
    logic [31:0] load_data_out;
    logic        load_valid_out;
    logic        fault_out;
    logic [1:0]  fault_cause_out;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_if bus ();

    mem_access_controller #(.TIMEOUT_CYCLES(TO), .CNT_W(10)) dut (
        .clock           (clock),
        .reset           (reset),
        .mem_read_in     (mem_read_in),
        .mem_write_in    (mem_write_in),
        .funct3_in       (funct3_in),
        .addr_in         (addr_in),
        .store_data_in   (store_data_in),
        .stall_out       (stall_out),
        .load_data_out   (load_data_out),
        .load_valid_out  (load_valid_out),
        .fault_out       (fault_out),
        .fault_cause_out (fault_cause_out),
        .dmem            (bus.master)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: access size in bytes, 0 for an unknown code.
    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit legal_m(input logic rd, input logic wr, input logic [2:0] f3);
        if (rd && wr) return 0;
        if (rd) return (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        if (wr) return (f3 == 0 || f3 == 1 || f3 == 2);
        return 0;
    endfunction

    function automatic logic [31:0] load_m(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rdata);
        logic [31:0] v;
        logic [31:0] mask;
        int sz;
        sz = size_of(f3);
        v = rdata >> (8 * off);
        if (sz == 4) return rdata;
        mask = (32'd1 << (8 * sz)) - 32'd1;
        v = v & mask;
        if (f3[2] == 1'b0 && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic do_reset();
        @(posedge clock); #2;
        reset = 1'b1;
        mem_read_in = 1'b0;
        mem_write_in = 1'b0;
        bus.dmem_ack = 1'b0;
        @(posedge clock); #2;
        check("rst_stall", 32'(stall_out), 32'd0);
        check("rst_req", 32'(bus.dmem_req), 32'd0);
        check("rst_we", 32'(bus.dmem_we), 32'd0);
        check("rst_addr", bus.dmem_addr, 32'd0);
        check("rst_be", 32'(bus.dmem_be), 32'd0);
        check("rst_wdata", bus.dmem_wdata, 32'd0);
        check("rst_ldata", load_data_out, 32'd0);
        check("rst_valid", 32'(load_valid_out), 32'd0);
        check("rst_fault", 32'(fault_out), 32'd0);
        check("rst_cause", 32'(fault_cause_out), 32'd0);
        reset = 1'b0;
    endtask

    // ack_at: WAIT cycle (1-based) on which memory acknowledges; 0 = never.
    task automatic run_access(input string name, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic [31:0] rdata,
                              input int ack_at);
        int sz;
        bit ok, mis, success;
        int stalls, reqs, valids, vstall;
        logic [31:0] ld;
        logic [31:0] exp_be, exp_wd;
        logic [1:0] exp_cause;

        sz = size_of(f3);
        ok = legal_m(rd, wr, f3);
        mis = ok && ((sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'b00));
        success = ok && !mis && ack_at >= 1 && ack_at <= TO;
        if (rd) exp_be = 32'hF;
        else exp_be = ((32'd1 << sz) - 32'd1) << addr[1:0];
        if (sz == 1) exp_wd = (sdata & 32'hFF) * 32'h01010101;
        else if (sz == 2) exp_wd = (sdata & 32'hFFFF) * 32'h00010001;
        else exp_wd = sdata;
        exp_cause = !ok ? 2'd2 : mis ? 2'd1 : !success ? 2'd3 : 2'd0;

        stalls = 0; reqs = 0; valids = 0; vstall = 0; ld = 32'd0;
        @(posedge clock); #2;
        mem_read_in = rd;
        mem_write_in = wr;
        funct3_in = f3;
        addr_in = addr;
        store_data_in = sdata;
        #1;
        for (int c = 0; c < L; c++) begin
            if (stall_out) stalls++;
            if (load_valid_out) begin
                valids++;
                ld = load_data_out;
                if (stall_out) vstall++;
            end
            bus.dmem_ack = 1'b0;
            if (bus.dmem_req) begin
                reqs++;
                if (reqs == 1) begin
                    check({name, "_addr"}, bus.dmem_addr, {addr[31:2], 2'b00});
                    check({name, "_be"}, 32'(bus.dmem_be), exp_be);
                    check({name, "_we"}, 32'(bus.dmem_we), 32'(wr));
                    if (wr) check({name, "_wdata"}, bus.dmem_wdata, exp_wd);
                end
                if (reqs == ack_at) begin
                    bus.dmem_ack = 1'b1;
                    bus.dmem_rdata = rdata;
                end
            end
            if (c >= 1) begin
                mem_read_in = 1'b0;
                mem_write_in = 1'b0;
            end
            @(posedge clock); #3;
        end
        bus.dmem_ack = 1'b0;
        check({name, "_stalls"}, 32'(stalls), success ? 32'(1 + ack_at) : 32'(L));
        check({name, "_reqs"}, 32'(reqs), success ? 32'(ack_at) : ((ok && !mis) ? 32'(TO) : 32'd0));
        check({name, "_valids"}, 32'(valids), (success && rd) ? 32'd1 : 32'd0);
        check({name, "_valid_stall"}, 32'(vstall), 32'd0);
        if (success && rd) check({name, "_ldata"}, ld, load_m(f3, addr[1:0], rdata));
        check({name, "_fault"}, 32'(fault_out), success ? 32'd0 : 32'd1);
        check({name, "_cause"}, 32'(fault_cause_out), 32'(exp_cause));
        if (!success) do_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rd, wr;
        logic [2:0] f3;
        logic [31:0] addr;
        int r, sz, ack_at;
        logic [2:0] ld_codes [5];
        ld_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = 32'd0;
        do_reset();

        run_access("sw100", 1'b0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 1);
        run_access("lb203", 1'b1, 1'b0, 3'd0, 32'h203, 32'h0, 32'h80FF0000, 4);
        run_access("lhu202", 1'b1, 1'b0, 3'd5, 32'h202, 32'h0, 32'h80011234, 2);
        run_access("sh206", 1'b0, 1'b1, 3'd1, 32'h206, 32'h0000ABCD, 32'h0, 1);
        run_access("lw101", 1'b1, 1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 1);
        run_access("tmo", 1'b1, 1'b0, 3'd2, 32'h400, 32'h0, 32'h12345678, 0);
        run_access("ack_lim", 1'b1, 1'b0, 3'd2, 32'h400, 32'h0, 32'h12345678, TO);
        run_access("rdwr", 1'b1, 1'b1, 3'd0, 32'h10, 32'h0, 32'h0, 1);
        run_access("badf3", 1'b0, 1'b1, 3'd4, 32'h10, 32'h0, 32'h0, 1);

        // Reset during WAIT followed by a late ack.
        @(posedge clock); #2;
        mem_read_in = 1'b1; funct3_in = 3'd2; addr_in = 32'h300;
        @(posedge clock); #2;
        mem_read_in = 1'b0;
        @(posedge clock); #2;
        check("midrst_req_before", 32'(bus.dmem_req), 32'd1);
        reset = 1'b1;
        @(posedge clock); #2;
        check("midrst_req_after", 32'(bus.dmem_req), 32'd0);
        reset = 1'b0;
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'hCAFEF00D;
        @(posedge clock); #2;
        bus.dmem_ack = 1'b0;
        check("late_ack_req", 32'(bus.dmem_req), 32'd0);
        check("late_ack_valid", 32'(load_valid_out), 32'd0);
        check("late_ack_stall", 32'(stall_out), 32'd0);
        check("late_ack_fault", 32'(fault_out), 32'd0);
        run_access("lw_after", 1'b1, 1'b0, 3'd2, 32'h304, 32'h0, 32'hA5A55A5A, 2);

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 19);
            if (r < 9) begin
                rd = 1'b1; wr = 1'b0; f3 = ld_codes[$urandom_range(0, 4)];
            end else if (r < 18) begin
                rd = 1'b0; wr = 1'b1; f3 = 3'($urandom_range(0, 2));
            end else if (r == 18) begin
                rd = 1'b1; wr = 1'b1; f3 = 3'($urandom);
            end else begin
                rd = 1'($urandom); wr = !rd; f3 = 3'($urandom);
            end
            addr = $urandom;
            sz = size_of(f3);
            if (sz > 0 && $urandom_range(0, 3) != 0) addr = addr & ~(32'(sz) - 32'd1);
            ack_at = $urandom_range(0, TO + 2);
            if ($urandom_range(0, 3) != 0) ack_at = $urandom_range(1, TO);
            run_access("rnd", rd, wr, f3, addr, $urandom, $urandom, ack_at);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
